// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window scanner.
package conv_pkg;

  // Layer sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of one registered int8 x int8 product.
  localparam int PROD_W = 16;

  // Signed pixel / weight byte.
  typedef logic signed [7:0] byte_t;

  // Counter width for a range of n values, never less than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/win_counter.sv
// Wrapping up-counter 0..MAX-1. wrap is high on the enabled cycle that
// rolls the count back to 0, so chaining wrap into the next enable builds
// a multi-digit scan counter.
module win_counter #(
  parameter int MAX = 3,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         xrst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == W'(MAX - 1));

  // Count on enable, roll to zero after MAX-1.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/conv_window_seq.sv
// KxK window scanner with multiply-accumulate over N_FILT filters, one tap
// per cycle, emitting one signed sum per output pixel on a valid/ready port.
// Optional feature macro: RELU_EN clamps negative window sums to zero.
module conv_window_seq
  import conv_pkg::*;
#(
  parameter int K       = 3,
  parameter int OUT_W   = 19,
  parameter int OUT_H   = 19,
  parameter int N_FILT  = 16,
  parameter int IADDR_W = 9,
  parameter int WADDR_W = 4,
  parameter int OADDR_W = 13,
  parameter int ACC_W   = 20
) (
  input  logic                 clk,
  input  logic                 xrst,
  input  logic                 start,
  output logic                 busy,
  output logic                 finish,
  output logic [IADDR_W-1:0]   img_raddr,
  output logic                 img_ren,
  input  logic [7:0]           img_rdata,
  output logic [WADDR_W-1:0]   w_raddr,
  output logic                 w_ren,
  input  logic [8*K*K-1:0]     w_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic [OADDR_W-1:0]   out_addr
);

  localparam int IN_W  = OUT_W + K - 1;
  localparam int IN_H  = OUT_H + K - 1;
  localparam int KK    = K * K;
  localparam int KW    = cw(K);
  localparam int XW    = cw(OUT_W);
  localparam int YW    = cw(OUT_H);
  localparam int FW    = cw(N_FILT);
  localparam int TAP_W = cw(KK);

  if (ACC_W < PROD_W + $clog2(KK)) begin : g_acc_chk
    $error("conv_window_seq: ACC_W too narrow for K*K products");
  end
  if ((1 << IADDR_W) < IN_W * IN_H) begin : g_iaddr_chk
    $error("conv_window_seq: IADDR_W too narrow for image");
  end

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
  endfunction

  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] a);
`ifdef RELU_EN
    return (a < 0) ? '0 : a;
`else
    return a;
`endif
  endfunction

  state_t state, state_nxt;
  logic   adv, issue;

  logic [KW-1:0] kx, ky;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;
  logic [FW-1:0] fi;
  logic          kx_wrap, ky_wrap, ox_wrap, oy_wrap, fi_wrap;

  logic [TAP_W-1:0]   tap_s0;
  logic [OADDR_W-1:0] oaddr_s0;

  logic                      vld_p1, first_p1, last_p1;
  logic [TAP_W-1:0]          tap_p1;
  logic [OADDR_W-1:0]        oaddr_p1;
  byte_t                     pix_s1, wt_s1;
  logic signed [PROD_W-1:0]  prod_s1;

  logic                      vld_p2, first_p2, last_p2;
  logic signed [PROD_W-1:0]  prod_p2;
  logic [OADDR_W-1:0]        oaddr_p2;
  logic signed [ACC_W-1:0]   sum_s2;

  logic signed [ACC_W-1:0]   acc_p3;

  // Whole datapath stalls only while a finished sum waits for the consumer.
  assign adv    = !(out_valid && !out_ready);
  assign issue  = adv && (state == RUN);
  assign busy   = (state != IDLE);
  assign finish = (state == DONE);

  // ---- S0: scan counters and read address issue ----
  win_counter #(.MAX(K),      .W(KW)) u_kx (.clk(clk), .xrst(xrst), .en(issue),   .cnt(kx), .wrap(kx_wrap));
  win_counter #(.MAX(K),      .W(KW)) u_ky (.clk(clk), .xrst(xrst), .en(kx_wrap), .cnt(ky), .wrap(ky_wrap));
  win_counter #(.MAX(OUT_W),  .W(XW)) u_ox (.clk(clk), .xrst(xrst), .en(ky_wrap), .cnt(ox), .wrap(ox_wrap));
  win_counter #(.MAX(OUT_H),  .W(YW)) u_oy (.clk(clk), .xrst(xrst), .en(ox_wrap), .cnt(oy), .wrap(oy_wrap));
  win_counter #(.MAX(N_FILT), .W(FW)) u_fi (.clk(clk), .xrst(xrst), .en(oy_wrap), .cnt(fi), .wrap(fi_wrap));

  assign img_raddr = IADDR_W'((int'(oy) + int'(ky)) * IN_W + int'(ox) + int'(kx));
  assign w_raddr   = WADDR_W'(fi);
  assign img_ren   = adv && busy;
  assign w_ren     = img_ren;
  assign tap_s0    = TAP_W'(int'(ky) * K + int'(kx));
  assign oaddr_s0  = OADDR_W'(int'(fi) * OUT_W * OUT_H + int'(oy) * OUT_W + int'(ox));

  // Layer state register.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: the layer ends once the final sum leaves with nothing behind it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && fi_wrap) state_nxt = DRAIN;
      DRAIN:   if (out_valid && out_ready && !vld_p1 && !vld_p2) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- S0 -> S1: tap tag travels with the read ----
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      tap_p1   <= '0;
      oaddr_p1 <= '0;
    end else if (adv) begin
      vld_p1   <= issue;
      first_p1 <= (kx == '0) && (ky == '0);
      last_p1  <= (kx == KW'(K - 1)) && (ky == KW'(K - 1));
      tap_p1   <= tap_s0;
      oaddr_p1 <= oaddr_s0;
    end
  end

  assign pix_s1  = img_rdata;
  assign wt_s1   = w_rdata[8*tap_p1 +: 8];
  assign prod_s1 = PROD_W'(pix_s1) * PROD_W'(wt_s1);

  // ---- S1 -> S2: registered signed product ----
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      vld_p2   <= 1'b0;
      first_p2 <= 1'b0;
      last_p2  <= 1'b0;
      prod_p2  <= '0;
      oaddr_p2 <= '0;
    end else if (adv) begin
      vld_p2   <= vld_p1;
      first_p2 <= first_p1;
      last_p2  <= last_p1;
      prod_p2  <= prod_s1;
      oaddr_p2 <= oaddr_p1;
    end
  end

  assign sum_s2 = first_p2 ? sext_prod(prod_p2) : acc_p3 + sext_prod(prod_p2);

  // ---- S2 -> out: accumulate, publish sum on the last tap of a window ----
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      acc_p3    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else if (adv) begin
      if (vld_p2) acc_p3 <= sum_s2;
      out_valid <= vld_p2 && last_p2;
      if (vld_p2 && last_p2) begin
        out_data <= relu(sum_s2);
        out_addr <= oaddr_p2;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_seq.sv
// Scoreboard bench for conv_window_seq: K=3, 2x2 outputs, 2 filters.
module tb_conv_window_seq;

  localparam int K = 3, OUT_W = 2, OUT_H = 2, N_FILT = 2;
  localparam int IN_W = OUT_W + K - 1;
  localparam int NPIX = IN_W * (OUT_H + K - 1);
  localparam int NOUT = N_FILT * OUT_W * OUT_H;

  logic        clk = 1'b0;
  logic        xrst, start, out_ready;
  logic        busy, finish, img_ren, w_ren, out_valid;
  logic [8:0]  img_raddr;
  logic [3:0]  w_raddr;
  logic [7:0]  img_rdata;
  logic [71:0] w_rdata;
  logic [19:0] out_data;
  logic [12:0] out_addr;

  logic signed [7:0] img [NPIX];
  logic [71:0]       wmem [N_FILT];

  int exp_data[$];
  int exp_addr[$];
  int n_tests = 0, n_fail = 0, n_out = 0, fin_cnt = 0;

  conv_window_seq #(.K(K), .OUT_W(OUT_W), .OUT_H(OUT_H), .N_FILT(N_FILT)) dut (
    .clk(clk), .xrst(xrst), .start(start), .busy(busy), .finish(finish),
    .img_raddr(img_raddr), .img_ren(img_ren), .img_rdata(img_rdata),
    .w_raddr(w_raddr), .w_ren(w_ren), .w_rdata(w_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  // Synchronous memories that hold their data while read enable is low.
  always @(posedge clk) begin
    if (img_ren) img_rdata <= (int'(img_raddr) < NPIX) ? img[img_raddr] : 8'h00;
    if (w_ren)   w_rdata   <= (int'(w_raddr) < N_FILT) ? wmem[w_raddr] : '0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is matched against the scoreboard.
  always @(negedge clk) begin
    if (xrst && out_valid && out_ready) begin
      n_out++;
      if (exp_data.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        check("out_data", int'($signed(out_data)), exp_data.pop_front());
        check("out_addr", int'(out_addr), exp_addr.pop_front());
      end
    end
  end

  always @(negedge clk) if (finish) fin_cnt++;

  function automatic int wt(input int f, input int b);
    logic [71:0] row;
    row = wmem[f];
    return int'($signed(row[8*b +: 8]));
  endfunction

  // Reference: direct nested-loop convolution over the current memories.
  task automatic push_layer();
    for (int f = 0; f < N_FILT; f++)
      for (int oy = 0; oy < OUT_H; oy++)
        for (int ox = 0; ox < OUT_W; ox++) begin
          int s;
          s = 0;
          for (int y = 0; y < K; y++)
            for (int x = 0; x < K; x++)
              s += int'(img[(oy + y) * IN_W + ox + x]) * wt(f, y * K + x);
`ifdef RELU_EN
          if (s < 0) s = 0;
`endif
          exp_data.push_back(s);
          exp_addr.push_back(f * OUT_W * OUT_H + oy * OUT_W + ox);
        end
  endtask

  task automatic fill_img(input int mode, input int val);
    for (int i = 0; i < NPIX; i++) img[i] = (mode == 0) ? 8'(val) : 8'(i);
  endtask

  task automatic fill_w(input int f, input int val);
    for (int b = 0; b < K * K; b++) wmem[f][8*b +: 8] = 8'(val);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_finish"}, int'(finish), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_addr"}, int'(out_addr), 0);
    check({tag, "_img_ren"}, int'(img_ren), 0);
    check({tag, "_w_ren"}, int'(w_ren), 0);
    check({tag, "_img_raddr"}, int'(img_raddr), 0);
    check({tag, "_w_raddr"}, int'(w_raddr), 0);
  endtask

  // Wait for the finish pulse; optionally keep start high until then.
  task automatic wait_fin(input bit hold, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!hold || finish) start = 1'b0;
    end while (!finish && cyc < 3000);
    if (!finish) check("finish_timeout", 0, 1);
    start = 1'b0;
  endtask

  task automatic post_layer(input string tag, input int out0, input int fin0);
    repeat (6) @(negedge clk);
    check({tag, "_finish_once"}, fin_cnt - fin0, 1);
    check({tag, "_n_outputs"}, n_out - out0, NOUT);
    check({tag, "_queue_empty"}, exp_data.size(), 0);
    check({tag, "_busy_low"}, int'(busy), 0);
  endtask

  task automatic run_layer(input string tag, input bit hold, output int cyc);
    int out0, fin0;
    out0 = n_out;
    fin0 = fin_cnt;
    push_layer();
    start = 1'b1;
    wait_fin(hold, cyc);
    post_layer(tag, out0, fin0);
  endtask

  initial begin
    int cyc, out0, fin0, f_data, f_addr, f_ia, f_wa;
    bit seen;
    xrst = 1'b0; start = 1'b0; out_ready = 1'b1;
    fill_img(0, 1); fill_w(0, 1); fill_w(1, 1);
    repeat (3) @(negedge clk);
    check_idle("reset");
    xrst = 1'b1;
    @(negedge clk);

    // 1: all ones -> every sum is 9, K*K cycles per output with no bubbles.
    run_layer("t1", 1'b0, cyc);
    check("t1_layer_cycles", cyc, NOUT * K * K + 4);

    // 2: centre tap only -> each sum is the centre pixel of its window.
    fill_img(1, 0);
    fill_w(0, 0); fill_w(1, 0);
    wmem[0][8*4 +: 8] = 8'd1;
    wmem[1][8*4 +: 8] = 8'd1;
    run_layer("t2", 1'b0, cyc);

    // 3: extreme operands; 9 * 16384 = 147456 fits in 20 bits.
    fill_img(0, -128); fill_w(0, -128); fill_w(1, -128);
    run_layer("t3a", 1'b0, cyc);
    fill_w(0, 127); fill_w(1, 127);
    run_layer("t3b", 1'b0, cyc);

    // 4: consumer stalls for 10 cycles on a pending output.
    fill_img(1, 0); fill_w(0, 1); fill_w(1, -1);
    out0 = n_out; fin0 = fin_cnt;
    push_layer();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #2;
      if (out_valid) seen = 1'b1;
    end
    check("t4_saw_valid", int'(seen), 1);
    out_ready = 1'b0;
    f_data = int'(out_data); f_addr = int'(out_addr);
    f_ia = int'(img_raddr); f_wa = int'(w_raddr);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      check("t4_valid_held", int'(out_valid), 1);
      check("t4_data_held", int'(out_data), f_data);
      check("t4_addr_held", int'(out_addr), f_addr);
      check("t4_img_raddr_held", int'(img_raddr), f_ia);
      check("t4_w_raddr_held", int'(w_raddr), f_wa);
      check("t4_img_ren_low", int'(img_ren), 0);
    end
    out_ready = 1'b1;
    wait_fin(1'b0, cyc);
    post_layer("t4", out0, fin0);

    // 5: reset mid-run aborts the layer without a finish pulse.
    fin0 = fin_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    xrst = 1'b0;
    #1;
    check_idle("t5_abort");
    exp_data.delete(); exp_addr.delete();
    repeat (2) @(negedge clk);
    out0 = n_out;
    xrst = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_no_finish", fin_cnt - fin0, 0);
    check("t5_no_output", n_out - out0, 0);
    run_layer("t5_fresh", 1'b0, cyc);

    // 6: start held high through the layer; filter 1 uses distinct weights.
    fill_w(0, 1); fill_w(1, 2);
    run_layer("t6", 1'b1, cyc);
    repeat (10) @(negedge clk);
    check("t6_single_layer", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
